// File: rtl/config_logic_array_if.sv
// Configuration handshake and fabric I/O bundle for config_logic_array.
// The master drives configuration/run controls and inputs; the slave (the array) returns ready/done and tile outputs.
interface config_logic_array_if #(
    parameter int NUM_INPUTS = 8,
    parameter int NUM_TILES  = 4
);
    logic                  cfg_start;
    logic                  cfg_valid;
    logic                  cfg_data;
    logic                  cfg_ready;
    logic                  cfg_done;
    logic                  run_en;
    logic [NUM_INPUTS-1:0] in;
    logic [NUM_TILES-1:0]  out;

    modport master (
        output cfg_start, cfg_valid, cfg_data, run_en, in,
        input  cfg_ready, cfg_done, out
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, run_en, in,
        output cfg_ready, cfg_done, out
    );
endinterface

// File: rtl/config_logic_array.sv
// Run-time programmable LUT fabric: serial bit-per-cycle config load, then NUM_TILES LUT+FF tiles run.
// Output is combinational (reg_sel=0) or one cycle (reg_sel=1); config accepted only while cfg_ready, stalls on cfg_valid=0.
module config_logic_array #(
    parameter int K          = 4,
    parameter int NUM_TILES  = 4,
    parameter int NUM_INPUTS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    config_logic_array_if.slave bus
);
    localparam int LUT_N     = 1 << K;
    localparam int SEL_W     = $clog2(NUM_INPUTS + NUM_TILES);
    localparam int SRC_N     = 1 << SEL_W;
    localparam int TILE_BITS = LUT_N + 1 + K * SEL_W;
    localparam int CFG_BITS  = NUM_TILES * TILE_BITS;
    localparam int CNT_W     = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                state;
    logic [CFG_BITS-1:0]   cfg;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_TILES-1:0]  q;
    logic [NUM_TILES-1:0]  lut_out;
    logic [NUM_TILES-1:0]  tile_out;
    logic                  cfg_ready_r;
    logic                  cfg_done_r;
    logic [SRC_N-1:0]      src;

    // cfg_start overrides everything, including a same-cycle data bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cfg         <= '0;
            cnt         <= '0;
            q           <= '0;
            cfg_ready_r <= 1'b0;
            cfg_done_r  <= 1'b0;
        end else if (bus.cfg_start) begin
            state       <= LOADING;
            cnt         <= '0;
            q           <= '0;
            cfg_ready_r <= 1'b1;
            cfg_done_r  <= 1'b0;
        end else begin
            case (state)
                LOADING: begin
                    if (bus.cfg_valid && cfg_ready_r) begin
                        cfg <= {bus.cfg_data, cfg[CFG_BITS-1:1]};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(CFG_BITS - 1)) begin
                            state       <= RUN;
                            cfg_ready_r <= 1'b0;
                            cfg_done_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.run_en) begin
                        q <= lut_out;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state       <= IDLE;
                    cfg_ready_r <= 1'b0;
                    cfg_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Routing sources: primary inputs, then tile flip-flops, then constant zero.
    always_comb begin
        src                         = '0;
        src[NUM_INPUTS-1:0]         = bus.in;
        src[NUM_INPUTS +: NUM_TILES] = q;
    end

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        logic [TILE_BITS-1:0] tcfg;
        logic [LUT_N-1:0]     table_bits;
        logic [K-1:0]         idx;

        assign tcfg       = cfg[t*TILE_BITS +: TILE_BITS];
        assign table_bits = tcfg[LUT_N-1:0];

        always_comb begin
            idx = '0;
            for (int j = 0; j < K; j++) begin
                idx[j] = src[tcfg[LUT_N + 1 + j*SEL_W +: SEL_W]];
            end
        end

        assign lut_out[t]  = table_bits[idx];
        assign tile_out[t] = tcfg[LUT_N] ? q[t] : lut_out[t];
    end

    assign bus.cfg_ready = cfg_ready_r;
    assign bus.cfg_done  = cfg_done_r;
    assign bus.out       = (state == RUN) ? tile_out : '0;
endmodule
